nibble_add8_sched: RTL



---
 rtl/nibble_add8_pkg.sv | 26 ++
 rtl/nibble_add_slice.sv | 31 +++
 rtl/nibble_add8_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/nibble_add8_pkg.sv
// Shared types and widths for the nibble-serial 8-bit add scheduler.
// Optional subtract support is enabled by NIBBLE_ADD8_SUB_EN.
package nibble_add8_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned OPND_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic              sub;
  } req_t;

  // Subtraction is a + ~b + 1; the +1 enters as the low-nibble carry-in.
  function automatic logic [OPND_W-1:0] slice_b(input req_t r);
    return r.sub ? ~r.b : r.b;
  endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// 4-bit adder slice with a registered carry chaining successive nibbles.
module nibble_add_slice
  import nibble_add8_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                cin_force,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout_next
);

  logic carry_q;
  logic cin;

  assign cin = cin_force | carry_q;
  assign {cout_next, sum} = (NIBBLE_W + 1)'(x) + (NIBBLE_W + 1)'(y) + (NIBBLE_W + 1)'(cin);

  // clr wins over en so a nibble sequence can consume and drop the carry together.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      carry_q <= 1'b0;
    end else if (en) begin
      carry_q <= cout_next;
    end
  end

endmodule

// File: rtl/nibble_add8_sched.sv
// Round-robin two-requester scheduler sequencing 8-bit adds through one nibble slice.
// Define NIBBLE_ADD8_SUB_EN to add per-requester subtract controls.
module nibble_add8_sched
  import nibble_add8_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_val,
  output logic              req0_rdy,
  input  logic [OPND_W-1:0] req0_a,
  input  logic [OPND_W-1:0] req0_b,
`ifdef NIBBLE_ADD8_SUB_EN
  input  logic              req0_sub,
`endif
  input  logic              req1_val,
  output logic              req1_rdy,
  input  logic [OPND_W-1:0] req1_a,
  input  logic [OPND_W-1:0] req1_b,
`ifdef NIBBLE_ADD8_SUB_EN
  input  logic              req1_sub,
`endif
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic [OPND_W-1:0] resp_sum,
  output logic              resp_cout,
  output logic              resp_id
);

  state_e            state_q;
  logic              prio_q;
  req_t              opnd_q;
  logic              id_q;
  logic [OPND_W-1:0] sum_q;
  logic              cout_q;
  logic              resp_val_q;

  req_t              req0_d;
  req_t              req1_d;
  logic              grant0;
  logic              grant1;
  logic              grant_any;

  logic [OPND_W-1:0] b_eff;
  logic [NIBBLE_W-1:0] slc_x;
  logic [NIBBLE_W-1:0] slc_y;
  logic [NIBBLE_W-1:0] slc_sum;
  logic              slc_cout;
  logic              slc_clr;
  logic              slc_en;
  logic              slc_cin_force;

  always_comb begin
    req0_d.a   = req0_a;
    req0_d.b   = req0_b;
    req1_d.a   = req1_a;
    req1_d.b   = req1_b;
`ifdef NIBBLE_ADD8_SUB_EN
    req0_d.sub = req0_sub;
    req1_d.sub = req1_sub;
`else
    req0_d.sub = 1'b0;
    req1_d.sub = 1'b0;
`endif
  end

  // Lone requester wins; on contention prio decides. Held off during reset so no grant is lost.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if ((state_q == IDLE) && !reset) begin
      grant0 = req0_val && (!req1_val || !prio_q);
      grant1 = req1_val && (!req0_val ||  prio_q);
    end
    grant_any = grant0 | grant1;
  end

  assign req0_rdy = grant0;
  assign req1_rdy = grant1;

  always_comb begin
    b_eff         = slice_b(opnd_q);
    slc_x         = opnd_q.a[NIBBLE_W-1:0];
    slc_y         = b_eff[NIBBLE_W-1:0];
    slc_en        = 1'b0;
    slc_clr       = 1'b0;
    slc_cin_force = 1'b0;
    case (state_q)
      IDLE: slc_clr = grant_any;
      LO: begin
        slc_en        = 1'b1;
        slc_cin_force = opnd_q.sub;
      end
      HI: begin
        slc_x   = opnd_q.a[OPND_W-1:NIBBLE_W];
        slc_y   = b_eff[OPND_W-1:NIBBLE_W];
        slc_clr = 1'b1;
      end
      default: ;
    endcase
  end

  nibble_add_slice u_slice (
    .clk       (clk),
    .reset     (reset),
    .clr       (slc_clr),
    .en        (slc_en),
    .x         (slc_x),
    .y         (slc_y),
    .cin_force (slc_cin_force),
    .sum       (slc_sum),
    .cout_next (slc_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      opnd_q     <= '0;
      id_q       <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      resp_val_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            opnd_q  <= grant1 ? req1_d : req0_d;
            id_q    <= grant1;
            prio_q  <= ~grant1;
            state_q <= LO;
          end
        end
        LO: begin
          sum_q[NIBBLE_W-1:0] <= slc_sum;
          state_q             <= HI;
        end
        HI: begin
          sum_q[OPND_W-1:NIBBLE_W] <= slc_sum;
          cout_q                   <= slc_cout;
          resp_val_q               <= 1'b1;
          state_q                  <= RESP;
        end
        RESP: begin
          if (resp_rdy) begin
            resp_val_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_val  = resp_val_q;
  assign resp_sum  = sum_q;
  assign resp_cout = cout_q;
  assign resp_id   = id_q;

endmodule
